// File: rtl/hazard_pkg.sv
// hazard_pkg: shared ISA constants, Tuse/Tnew encodings, forward selects,
// scoreboard entry types and small match helpers for the hazard controller.
package hazard_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Funct codes under OP_RTYPE
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Tuse: cycles after D until the operand is consumed; NONE = not read
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew: cycles after E until the result exists in the pipeline
    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Forward-mux select encoding
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_t;

    // One scoreboard stage
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        logic [1:0] tnew;
    } sb_entry_t;

    // Decoded view of the D instruction
    typedef struct packed {
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic [4:0] a3;
        logic [1:0] tnew;
    } dec_t;

    function automatic logic src_used(input logic [1:0] tuse);
        return tuse != TUSE_NONE;
    endfunction

    // Stage writes the source register ($0 never counts)
    function automatic logic dep_hit(input sb_entry_t ent, input logic [4:0] src);
        return (src != REG_ZERO) && (ent.a3 == src);
    endfunction

    // Result will not be ready by the time the consumer needs it
    function automatic logic late_hit(input sb_entry_t ent, input logic [4:0] src,
                                      input logic [1:0] tuse);
        return src_used(tuse) && dep_hit(ent, src) && (ent.tnew > tuse);
    endfunction

    // Stage holds the final value of the source register right now
    function automatic logic fwd_ready(input sb_entry_t ent, input logic [4:0] src);
        return dep_hit(ent, src) && (ent.tnew == TNEW_0);
    endfunction

    // Tnew one stage further down, saturating at zero
    function automatic logic [1:0] tnew_step(input logic [1:0] t);
        return (t == TNEW_0) ? TNEW_0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: D-stage instruction fields in, stall/forward selects out.
// master = pipeline datapath side, slave = hazard controller.
interface hazard_ctrl_if;
    logic [5:0] op_d;
    logic [5:0] func_d;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] rd_d;
    logic       stall;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;
    logic [1:0] fwd_rt_m;
    logic [4:0] a3_w;
    logic [1:0] tnew_e;

    modport master (
        output op_d, func_d, rs_d, rt_d, rd_d,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, a3_w, tnew_e
    );

    modport slave (
        input  op_d, func_d, rs_d, rt_d, rd_d,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, a3_w, tnew_e
    );
endinterface

// File: rtl/hz_decode.sv
// hz_decode: combinational D-stage decode into per-operand Tuse,
// destination register and initial Tnew. rs is not needed here: it never
// names a destination.
module hz_decode
    import hazard_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    input  logic [4:0] rt_i,
    input  logic [4:0] rd_i,
    output dec_t       dec_o
);

    // Instruction table; anything unrecognised reads nothing and writes nothing
    always_comb begin
        dec_o.tuse_rs = TUSE_NONE;
        dec_o.tuse_rt = TUSE_NONE;
        dec_o.a3      = REG_ZERO;
        dec_o.tnew    = TNEW_0;
        case (op_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_ADDU, FN_SUBU: begin
                        dec_o.tuse_rs = TUSE_1;
                        dec_o.tuse_rt = TUSE_1;
                        dec_o.a3      = rd_i;
                        dec_o.tnew    = TNEW_1;
                    end
                    FN_JR: begin
                        dec_o.tuse_rs = TUSE_0;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                dec_o.tuse_rs = TUSE_1;
                dec_o.a3      = rt_i;
                dec_o.tnew    = TNEW_1;
            end
            OP_LUI: begin
                dec_o.a3   = rt_i;
                dec_o.tnew = TNEW_1;
            end
            OP_LW: begin
                dec_o.tuse_rs = TUSE_1;
                dec_o.a3      = rt_i;
                dec_o.tnew    = TNEW_2;
            end
            OP_SW: begin
                dec_o.tuse_rs = TUSE_1;
                dec_o.tuse_rt = TUSE_2;
            end
            OP_BEQ: begin
                dec_o.tuse_rs = TUSE_0;
                dec_o.tuse_rt = TUSE_0;
            end
            OP_JAL: begin
                // PC+8 is produced in E, so it is forwardable immediately
                dec_o.a3   = REG_RA;
                dec_o.tnew = TNEW_0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage MIPS core.
// Keeps an E/M/W scoreboard of {rs, rt, a3, tnew} and derives the global
// stall plus all forward selects combinationally from it and the D fields.
// Build option HAZARD_FWD_EN: defined = full forwarding with Tnew/Tuse
// stalls; undefined = no forwarding, stall on any E/M/W producer match.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    dec_t      dec_d;
    sb_entry_t sb_e_q, sb_m_q, sb_w_q;
    sb_entry_t sb_e_d, sb_m_d, sb_w_d;
    logic      stall_c;

    hz_decode u_dec (
        .op_i   (hz.op_d),
        .func_i (hz.func_d),
        .rt_i   (hz.rt_d),
        .rd_i   (hz.rd_d),
        .dec_o  (dec_d)
    );

    // Stall decision for the instruction sitting in D
    always_comb begin
        stall_c = 1'b0;
`ifdef HAZARD_FWD_EN
        // W always has tnew 0, so only E and M can be late
        stall_c = late_hit(sb_e_q, hz.rs_d, dec_d.tuse_rs)
                | late_hit(sb_m_q, hz.rs_d, dec_d.tuse_rs)
                | late_hit(sb_e_q, hz.rt_d, dec_d.tuse_rt)
                | late_hit(sb_m_q, hz.rt_d, dec_d.tuse_rt);
`else
        // No bypass network: wait until the producer has left W, since the
        // register file write only lands at the end of the W cycle
        stall_c = (src_used(dec_d.tuse_rs) &&
                   (dep_hit(sb_e_q, hz.rs_d) || dep_hit(sb_m_q, hz.rs_d) ||
                    dep_hit(sb_w_q, hz.rs_d)))
                | (src_used(dec_d.tuse_rt) &&
                   (dep_hit(sb_e_q, hz.rt_d) || dep_hit(sb_m_q, hz.rt_d) ||
                    dep_hit(sb_w_q, hz.rt_d)));
`endif
    end

    assign hz.stall = stall_c;

    // Forward selects: nearest stage whose result is already final wins
    always_comb begin
        hz.fwd_rs_d = FWD_RF;
        hz.fwd_rt_d = FWD_RF;
        hz.fwd_rs_e = FWD_RF;
        hz.fwd_rt_e = FWD_RF;
        hz.fwd_rt_m = FWD_RF;
`ifdef HAZARD_FWD_EN
        hz.fwd_rs_d = fwd_ready(sb_e_q, hz.rs_d) ? FWD_E :
                      fwd_ready(sb_m_q, hz.rs_d) ? FWD_M :
                      fwd_ready(sb_w_q, hz.rs_d) ? FWD_W : FWD_RF;
        hz.fwd_rt_d = fwd_ready(sb_e_q, hz.rt_d) ? FWD_E :
                      fwd_ready(sb_m_q, hz.rt_d) ? FWD_M :
                      fwd_ready(sb_w_q, hz.rt_d) ? FWD_W : FWD_RF;
        hz.fwd_rs_e = fwd_ready(sb_m_q, sb_e_q.rs) ? FWD_M :
                      fwd_ready(sb_w_q, sb_e_q.rs) ? FWD_W : FWD_RF;
        hz.fwd_rt_e = fwd_ready(sb_m_q, sb_e_q.rt) ? FWD_M :
                      fwd_ready(sb_w_q, sb_e_q.rt) ? FWD_W : FWD_RF;
        hz.fwd_rt_m = fwd_ready(sb_w_q, sb_m_q.rt) ? FWD_W : FWD_RF;
`endif
    end

    // Next scoreboard contents: a bubble enters E while D is held
    always_comb begin
        sb_e_d = stall_c ? '0 : '{rs: hz.rs_d, rt: hz.rt_d, a3: dec_d.a3, tnew: dec_d.tnew};
        sb_m_d      = sb_e_q;
        sb_m_d.tnew = tnew_step(sb_e_q.tnew);
        sb_w_d      = sb_m_q;
        sb_w_d.tnew = tnew_step(sb_m_q.tnew);
    end

    // Scoreboard advances every cycle, stalled or not
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_e_q <= '0;
            sb_m_q <= '0;
            sb_w_q <= '0;
        end else begin
            sb_e_q <= sb_e_d;
            sb_m_q <= sb_m_d;
            sb_w_q <= sb_w_d;
        end
    end

    assign hz.a3_w   = sb_w_q.a3;
    assign hz.tnew_e = sb_e_q.tnew;

    // Source fields that not every build variant consumes
    logic unused_sb;
    assign unused_sb = ^{sb_e_q.rs, sb_e_q.rt, sb_m_q.rs, sb_m_q.rt,
                         sb_w_q.rs, sb_w_q.rt, sb_w_q.tnew};

endmodule
